setting_editor: RTL and testbench
=================================

Name: setting_editor

Overview:
- Parameterised, clocked successor to the quiz-game settings block.
- Holds NUM_FIELDS committed game settings, each FIELD_W bits wide.
- Edits a working copy from board buttons and switches: field select, saturating up/down with auto-repeat, direct switch load, commit and cancel.
- Sits between the debounced board inputs and the game/display controllers. The game controller freezes it through lock while a round runs.

Parameters:
- NUM_FIELDS, 6, number of settings fields. Field order: player_count, question_count, answer_time, win_score, success_score, fail_score.
- FIELD_W, 7, width of each field.
- DEFAULTS, {7'd1,7'd1,7'd3,7'd10,7'd5,7'd2}, packed reset values; field 0 is in the LSBs.
- MINS, {7'd0,7'd0,7'd1,7'd1,7'd1,7'd1}, packed per-field minimum, inclusive.
- MAXS, {7'd15,7'd15,7'd99,7'd99,7'd15,7'd4}, packed per-field maximum, inclusive.
- REPEAT_DELAY, 25000000, cycles an up/down button must be held before the first auto-repeat step.
- REPEAT_PERIOD, 5000000, cycles between auto-repeat steps after REPEAT_DELAY.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- sw  in  24  board switches. sw[23] = cancel level, sw[22] = load strobe (level, edge-detected internally), sw[FIELD_W-1:0] = load value.
- bt  in  5  debounced buttons, active-high: [0] centre, [1] up, [2] down, [3] left, [4] right.
- lock  in  1  high while a game is in progress.
- settings  out  NUM_FIELDS*FIELD_W  committed values, packed; field 0 in the LSBs.
- field_sel  out  $clog2(NUM_FIELDS)  field currently being edited.
- edit_value  out  FIELD_W  working-copy value of field_sel.
- mode  out  2  0 = IDLE, 1 = EDIT, 2 = COMMIT, 3 = LOCKED.
- dirty  out  1  working copy differs from settings.
- commit  out  1  one-cycle pulse when settings is updated.

Behaviour:
- Reset (rst low, asynchronous):
  - settings and working copy = DEFAULTS.
  - field_sel = 0, mode = IDLE, commit = 0, dirty = 0.
  - Edge-detect registers and repeat counters are cleared.
  - Reset asserted in any mode discards the working copy.
- Button and strobe edges: a "press" is a 0->1 transition of registered bt[i] or sw[22]. Only presses act, apart from auto-repeat.
- Auto-repeat (up/down, EDIT only):
  - A press gives one step in the next cycle.
  - If the button stays held, one more step occurs REPEAT_DELAY cycles after the press, then one every REPEAT_PERIOD cycles.
  - Release clears the counter.
  - Up and down held together: no steps, and both counters are cleared.
- IDLE:
  - Centre press -> EDIT: working copy <= settings, field_sel <= 0.
  - All other inputs are ignored.
- EDIT, one action per cycle, in this priority order:
  1. Cancel (sw[23] = 1): discard the working copy, go to IDLE.
  2. Centre press: go to COMMIT.
  3. sw[22] press: working[field_sel] <= sw[FIELD_W-1:0], clamped to [MINS, MAXS] of that field.
  4. Up/down step: +1 / -1, saturating at the field MAX / MIN. No wrap.
  5. Left/right press: field_sel -1 / +1 with wrap-around (0 -> NUM_FIELDS-1 and back).
- COMMIT:
  - Lasts exactly one cycle; settings <= working, commit = 1, dirty cleared.
  - Next cycle -> IDLE, with commit back to 0.
- Lock:
  - lock = 1 in any mode -> LOCKED on the next edge; it takes priority over everything.
  - A pending edit is discarded and no commit occurs, even if centre is pressed in the same cycle.
  - A COMMIT already in progress completes first; LOCKED follows on the next edge.
  - In LOCKED, settings hold and buttons are ignored.
  - When lock = 0 -> IDLE.
- Outputs:
  - edit_value and dirty are combinational from registered state.
  - In IDLE and LOCKED, edit_value shows settings[field_sel] and dirty = 0.
  - settings changes only in COMMIT or on reset.

Decomposition:
- Shared package (settings_pkg):
  - mode encodings.
  - Button index constants: BT_CENTRE, BT_UP, BT_DOWN, BT_LEFT, BT_RIGHT.
  - Switch index constants: SW_CANCEL, SW_LOAD.
  - Field index constants: F_PLAYERS … F_FAIL.
- One sub-module, key_repeat:
  - One instance per up/down button.
  - Contains edge detect plus the REPEAT_DELAY/REPEAT_PERIOD counter.
  - Output is a single-cycle step pulse.

Test Plan (REPEAT_DELAY = 4, REPEAT_PERIOD = 2, other parameters default):
- Reset then release -> settings = DEFAULTS, mode = 0, commit = 0; centre press -> mode = 1, edit_value = 2 (field 0).
- EDIT, field 0 = 2; up pressed 3 times -> edit_value 4 (saturates); down pressed 5 times -> 1 (MIN); centre -> commit pulse for 1 cycle, settings[6:0] = 1, then mode = 0.
- EDIT: left press -> field_sel = 5; right press twice -> field_sel = 1; sw[7:0] = 120 with sw[22] rising on field 2 -> edit_value = 99.
- EDIT: hold up on field 2 (value 10) for 10 cycles -> steps at cycle 1 and at 4, 6, 8, 10 after the press -> 15; up and down held together -> value unchanged.
- EDIT with dirty = 1: raise sw[23] -> mode = 0, settings unchanged; re-enter EDIT, modify, assert lock together with a centre press -> mode = 3, no commit, settings unchanged; drop lock -> mode = 0.
- In EDIT, pull rst low mid-edit (asynchronously) -> outputs return to reset values immediately, settings = DEFAULTS.

Source files
------------

// File: rtl/settings_pkg.sv
// rtl/settings_pkg.sv - shared encodings and index constants for the settings editor
package settings_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_EDIT   = 2'd1,
        MODE_COMMIT = 2'd2,
        MODE_LOCKED = 2'd3
    } mode_t;

    localparam int BT_CENTRE = 0;
    localparam int BT_UP     = 1;
    localparam int BT_DOWN   = 2;
    localparam int BT_LEFT   = 3;
    localparam int BT_RIGHT  = 4;

    localparam int SW_CANCEL = 23;
    localparam int SW_LOAD   = 22;

    localparam int F_PLAYERS     = 0;
    localparam int F_QUESTIONS   = 1;
    localparam int F_ANSWER_TIME = 2;
    localparam int F_WIN         = 3;
    localparam int F_SUCCESS     = 4;
    localparam int F_FAIL        = 5;

endpackage

// File: rtl/key_repeat.sv
// rtl/key_repeat.sv - button edge detect with hold-to-repeat, emits one-cycle step pulses
module key_repeat #(
    parameter int DELAY  = 25000000,
    parameter int PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    input  logic en,
    input  logic inhibit,
    output logic held,
    output logic step
);

    localparam int CNT_MAX = (DELAY > PERIOD) ? DELAY : PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             key_r;
    logic             key_p;
    logic             rep;
    logic [CNT_W-1:0] cnt;
    logic             press;
    logic             fire;

    assign press = key_r & ~key_p;

    // cnt is the number of cycles since the last step; zero means no press seen yet
    assign fire = key_r && (cnt != '0) &&
                  (rep ? (cnt == CNT_W'(PERIOD)) : (cnt == CNT_W'(DELAY - 1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_r <= 1'b0;
            key_p <= 1'b0;
            rep   <= 1'b0;
            cnt   <= '0;
        end else begin
            key_r <= key;
            key_p <= key_r;
            if (!en || !key_r || inhibit) begin
                cnt <= '0;
                rep <= 1'b0;
            end else if (press) begin
                cnt <= CNT_W'(1);
                rep <= 1'b0;
            end else if (fire) begin
                cnt <= CNT_W'(1);
                rep <= 1'b1;
            end else if (cnt != '0) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign held = key_r;
    assign step = en & ~inhibit & (press | fire);

endmodule

// File: rtl/setting_editor.sv
// rtl/setting_editor.sv - committed game settings with a button-driven working copy
module setting_editor
    import settings_pkg::*;
#(
    parameter int NUM_FIELDS = 6,
    parameter int FIELD_W    = 7,
    parameter logic [NUM_FIELDS*FIELD_W-1:0] DEFAULTS = {7'd1, 7'd1, 7'd3, 7'd10, 7'd5, 7'd2},
    parameter logic [NUM_FIELDS*FIELD_W-1:0] MINS     = {7'd0, 7'd0, 7'd1, 7'd1, 7'd1, 7'd1},
    parameter logic [NUM_FIELDS*FIELD_W-1:0] MAXS     = {7'd15, 7'd15, 7'd99, 7'd99, 7'd15, 7'd4},
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [23:0]                      sw,
    input  logic [4:0]                       bt,
    input  logic                             lock,
    output logic [NUM_FIELDS*FIELD_W-1:0]    settings,
    output logic [$clog2(NUM_FIELDS)-1:0]    field_sel,
    output logic [FIELD_W-1:0]               edit_value,
    output logic [1:0]                       mode,
    output logic                             dirty,
    output logic                             commit
);

    localparam int TOTAL_W = NUM_FIELDS * FIELD_W;
    localparam int SEL_W   = $clog2(NUM_FIELDS);

    mode_t              state_q;
    mode_t              state_d;
    logic [TOTAL_W-1:0] set_q;
    logic [TOTAL_W-1:0] work_q;
    logic [SEL_W-1:0]   sel_q;
    logic [SEL_W-1:0]   sel_d;

    logic c_r, c_p, l_r, l_p, r_r, r_p, ld_r, ld_p;
    logic c_press, l_press, r_press, ld_press;
    logic up_step, dn_step, up_held, dn_held, both_held, editing;

    logic [FIELD_W-1:0] cur_work, cur_set, cur_min, cur_max;
    logic [FIELD_W-1:0] load_raw, load_val, wr_val;
    logic               load_work, do_commit, wr_en;

    logic unused_sw;
    assign unused_sw = ^sw[21:FIELD_W];

    assign c_press  = c_r & ~c_p;
    assign l_press  = l_r & ~l_p;
    assign r_press  = r_r & ~r_p;
    assign ld_press = ld_r & ~ld_p;

    assign editing   = (state_q == MODE_EDIT);
    assign both_held = up_held & dn_held;

    key_repeat #(.DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) u_up (
        .clk     (clk),
        .rst     (rst),
        .key     (bt[BT_UP]),
        .en      (editing),
        .inhibit (both_held),
        .held    (up_held),
        .step    (up_step)
    );

    key_repeat #(.DELAY(REPEAT_DELAY), .PERIOD(REPEAT_PERIOD)) u_dn (
        .clk     (clk),
        .rst     (rst),
        .key     (bt[BT_DOWN]),
        .en      (editing),
        .inhibit (both_held),
        .held    (dn_held),
        .step    (dn_step)
    );

    always_comb begin
        cur_work = '0;
        cur_set  = '0;
        cur_min  = '0;
        cur_max  = '0;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                cur_work = work_q[i*FIELD_W +: FIELD_W];
                cur_set  = set_q[i*FIELD_W +: FIELD_W];
                cur_min  = MINS[i*FIELD_W +: FIELD_W];
                cur_max  = MAXS[i*FIELD_W +: FIELD_W];
            end
        end
    end

    assign load_raw = sw[FIELD_W-1:0];
    assign load_val = (load_raw < cur_min) ? cur_min :
                      (load_raw > cur_max) ? cur_max : load_raw;

    // Lock outranks everything; settings are written on the edge into COMMIT
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        load_work = 1'b0;
        do_commit = 1'b0;
        wr_en     = 1'b0;
        wr_val    = cur_work;
        case (state_q)
            MODE_IDLE: begin
                if (lock) begin
                    state_d = MODE_LOCKED;
                end else if (c_press) begin
                    state_d   = MODE_EDIT;
                    load_work = 1'b1;
                    sel_d     = '0;
                end
            end
            MODE_EDIT: begin
                if (lock) begin
                    state_d = MODE_LOCKED;
                end else if (sw[SW_CANCEL]) begin
                    state_d = MODE_IDLE;
                end else if (c_press) begin
                    state_d   = MODE_COMMIT;
                    do_commit = 1'b1;
                end else if (ld_press) begin
                    wr_en  = 1'b1;
                    wr_val = load_val;
                end else if (up_step) begin
                    if (cur_work < cur_max) begin
                        wr_en  = 1'b1;
                        wr_val = cur_work + 1'b1;
                    end
                end else if (dn_step) begin
                    if (cur_work > cur_min) begin
                        wr_en  = 1'b1;
                        wr_val = cur_work - 1'b1;
                    end
                end else if (l_press) begin
                    sel_d = (sel_q == '0) ? SEL_W'(NUM_FIELDS - 1) : sel_q - 1'b1;
                end else if (r_press) begin
                    sel_d = (sel_q == SEL_W'(NUM_FIELDS - 1)) ? '0 : sel_q + 1'b1;
                end
            end
            default: begin
                state_d = lock ? MODE_LOCKED : MODE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MODE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q  <= '0;
            set_q  <= DEFAULTS;
            work_q <= DEFAULTS;
            c_r    <= 1'b0;
            c_p    <= 1'b0;
            l_r    <= 1'b0;
            l_p    <= 1'b0;
            r_r    <= 1'b0;
            r_p    <= 1'b0;
            ld_r   <= 1'b0;
            ld_p   <= 1'b0;
        end else begin
            sel_q <= sel_d;
            c_r   <= bt[BT_CENTRE];
            c_p   <= c_r;
            l_r   <= bt[BT_LEFT];
            l_p   <= l_r;
            r_r   <= bt[BT_RIGHT];
            r_p   <= r_r;
            ld_r  <= sw[SW_LOAD];
            ld_p  <= ld_r;
            if (load_work) begin
                work_q <= set_q;
            end else if (wr_en) begin
                for (int i = 0; i < NUM_FIELDS; i++) begin
                    if (sel_q == SEL_W'(i)) begin
                        work_q[i*FIELD_W +: FIELD_W] <= wr_val;
                    end
                end
            end
            if (do_commit) begin
                set_q <= work_q;
            end
        end
    end

    assign settings   = set_q;
    assign field_sel  = sel_q;
    assign mode       = state_q;
    assign commit     = (state_q == MODE_COMMIT);
    assign dirty      = editing && (work_q != set_q);
    assign edit_value = (editing || state_q == MODE_COMMIT) ? cur_work : cur_set;

endmodule

// File: tb/tb_setting_editor.sv
// tb/tb_setting_editor.sv - directed scoreboard bench for setting_editor
module tb_setting_editor;
    import settings_pkg::*;

    localparam int NF = 6;
    localparam int FW = 7;
    localparam int RD = 4;
    localparam int RP = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [23:0]       sw;
    logic [4:0]        bt;
    logic              lock;
    logic [NF*FW-1:0]  settings;
    logic [2:0]        field_sel;
    logic [FW-1:0]     edit_value;
    logic [1:0]        mode;
    logic              dirty;
    logic              commit;

    always #5 clk = ~clk;

    setting_editor #(
        .NUM_FIELDS    (NF),
        .FIELD_W       (FW),
        .REPEAT_DELAY  (RD),
        .REPEAT_PERIOD (RP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .bt         (bt),
        .lock       (lock),
        .settings   (settings),
        .field_sel  (field_sel),
        .edit_value (edit_value),
        .mode       (mode),
        .dirty      (dirty),
        .commit     (commit)
    );

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   def_m[NF], min_m[NF], max_m[NF], set_m[NF], work_m[NF];
    int   sel_m;

    function automatic logic [63:0] pack_set();
        logic [63:0] p = '0;
        for (int i = 0; i < NF; i++) p[i*FW +: FW] = FW'(set_m[i]);
        return p;
    endfunction

    task automatic want(string tag, logic [63:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic got(string tag, logic [63:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: got %0d, no expected value queued", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val && tag == e.tag)
            else begin
                bad++;
                $error("FAIL %s: got %0d want %0d (queued as %s)", tag, obs, e.val, e.tag);
            end
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tap(int b);
        bt[b] = 1'b1;
        cyc(1);
        bt[b] = 1'b0;
        cyc(2);
    endtask

    task automatic m_up();
        if (work_m[sel_m] < max_m[sel_m]) work_m[sel_m]++;
    endtask

    task automatic m_dn();
        if (work_m[sel_m] > min_m[sel_m]) work_m[sel_m]--;
    endtask

    task automatic enter_edit();
        work_m = set_m;
        sel_m  = 0;
        want("enter_mode", 64'(1));
        want("enter_val", 64'(work_m[0]));
        tap(BT_CENTRE);
        got("enter_mode", 64'(mode));
        got("enter_val", 64'(edit_value));
    endtask

    task automatic move(int b);
        if (b == BT_LEFT) sel_m = (sel_m == 0) ? NF - 1 : sel_m - 1;
        else              sel_m = (sel_m == NF - 1) ? 0 : sel_m + 1;
        want("sel", 64'(sel_m));
        tap(b);
        got("sel", 64'(field_sel));
    endtask

    task automatic load(int v);
        if (v < min_m[sel_m])      work_m[sel_m] = min_m[sel_m];
        else if (v > max_m[sel_m]) work_m[sel_m] = max_m[sel_m];
        else                       work_m[sel_m] = v;
        want("load", 64'(work_m[sel_m]));
        sw[7:0]     = v[7:0];
        sw[SW_LOAD] = 1'b1;
        cyc(3);
        got("load", 64'(edit_value));
        sw[SW_LOAD] = 1'b0;
        cyc(2);
    endtask

    task automatic hold(int b, int h);
        int n = 0;
        for (int k = 1; k <= h; k++) if (k == 1 || (k >= RD && (k - RD) % RP == 0)) n++;
        repeat (n) if (b == BT_UP) m_up(); else m_dn();
        want("hold", 64'(work_m[sel_m]));
        bt[b] = 1'b1;
        cyc(h);
        bt[b] = 1'b0;
        cyc(2);
        got("hold", 64'(edit_value));
    endtask

    task automatic cancel();
        work_m = set_m;
        want("cancel_mode", 64'(0));
        want("cancel_set", pack_set());
        want("cancel_dirty", 64'(0));
        want("cancel_val", 64'(set_m[sel_m]));
        sw[SW_CANCEL] = 1'b1;
        cyc(1);
        got("cancel_mode", 64'(mode));
        got("cancel_set", 64'(settings));
        got("cancel_dirty", 64'(dirty));
        got("cancel_val", 64'(edit_value));
        sw[SW_CANCEL] = 1'b0;
        cyc(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sw = '0; bt = '0; lock = 1'b0; rst = 1'b0;
        def_m[F_PLAYERS] = 2;  min_m[F_PLAYERS] = 1;  max_m[F_PLAYERS] = 4;
        def_m[F_QUESTIONS] = 5; min_m[F_QUESTIONS] = 1; max_m[F_QUESTIONS] = 15;
        def_m[F_ANSWER_TIME] = 10; min_m[F_ANSWER_TIME] = 1; max_m[F_ANSWER_TIME] = 99;
        def_m[F_WIN] = 3;      min_m[F_WIN] = 1;      max_m[F_WIN] = 99;
        def_m[F_SUCCESS] = 1;  min_m[F_SUCCESS] = 0;  max_m[F_SUCCESS] = 15;
        def_m[F_FAIL] = 1;     min_m[F_FAIL] = 0;     max_m[F_FAIL] = 15;
        set_m = def_m; work_m = def_m; sel_m = F_PLAYERS;

        // reset state
        want("rst_set", pack_set());
        want("rst_mode", 64'(0));
        want("rst_commit", 64'(0));
        want("rst_dirty", 64'(0));
        want("rst_sel", 64'(0));
        want("rst_val", 64'(def_m[F_PLAYERS]));
        cyc(3);
        rst = 1'b1;
        cyc(2);
        got("rst_set", 64'(settings));
        got("rst_mode", 64'(mode));
        got("rst_commit", 64'(commit));
        got("rst_dirty", 64'(dirty));
        got("rst_sel", 64'(field_sel));
        got("rst_val", 64'(edit_value));

        // saturating up/down and commit
        enter_edit();
        repeat (3) m_up();
        want("up_sat", 64'(work_m[0]));
        want("up_dirty", 64'(1));
        repeat (3) tap(BT_UP);
        got("up_sat", 64'(edit_value));
        got("up_dirty", 64'(dirty));
        repeat (5) m_dn();
        want("dn_sat", 64'(work_m[0]));
        repeat (5) tap(BT_DOWN);
        got("dn_sat", 64'(edit_value));

        set_m = work_m;
        want("cm_mode", 64'(2));
        want("cm_pulse", 64'(1));
        want("cm_set", pack_set());
        bt[BT_CENTRE] = 1'b1;
        cyc(1);
        bt[BT_CENTRE] = 1'b0;
        cyc(1);
        got("cm_mode", 64'(mode));
        got("cm_pulse", 64'(commit));
        got("cm_set", 64'(settings));
        want("cm_after_mode", 64'(0));
        want("cm_after_pulse", 64'(0));
        cyc(1);
        got("cm_after_mode", 64'(mode));
        got("cm_after_pulse", 64'(commit));

        // field wrap and clamped loads
        enter_edit();
        move(BT_LEFT);
        move(BT_RIGHT);
        move(BT_RIGHT);
        move(BT_RIGHT);
        load(120);
        load(0);
        load(50);
        want("load_dirty", 64'(1));
        cyc(1);
        got("load_dirty", 64'(dirty));
        cancel();

        // auto-repeat
        enter_edit();
        move(BT_RIGHT);
        move(BT_RIGHT);
        hold(BT_UP, 10);
        hold(BT_DOWN, 5);
        want("both", 64'(work_m[sel_m]));
        bt[BT_UP] = 1'b1;
        bt[BT_DOWN] = 1'b1;
        cyc(10);
        bt[BT_UP] = 1'b0;
        bt[BT_DOWN] = 1'b0;
        cyc(2);
        got("both", 64'(edit_value));
        want("rep_dirty", 64'(1));
        cyc(1);
        got("rep_dirty", 64'(dirty));
        cancel();

        // lock with simultaneous centre press discards the edit
        enter_edit();
        m_up();
        want("pre_lock_val", 64'(work_m[0]));
        tap(BT_UP);
        got("pre_lock_val", 64'(edit_value));
        want("lk_mode", 64'(3));
        want("lk_commit", 64'(0));
        want("lk_set", pack_set());
        want("lk_dirty", 64'(0));
        lock = 1'b1;
        bt[BT_CENTRE] = 1'b1;
        cyc(1);
        got("lk_mode", 64'(mode));
        got("lk_commit", 64'(commit));
        got("lk_set", 64'(settings));
        got("lk_dirty", 64'(dirty));
        bt[BT_CENTRE] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            want("lk_hold_commit", 64'(0));
            cyc(1);
            got("lk_hold_commit", 64'(commit));
        end
        want("lk_btn_val", 64'(set_m[0]));
        want("lk_btn_set", pack_set());
        tap(BT_UP);
        got("lk_btn_val", 64'(edit_value));
        got("lk_btn_set", 64'(settings));
        lock = 1'b0;
        want("unlock_mode", 64'(0));
        cyc(1);
        got("unlock_mode", 64'(mode));

        // lock arriving during COMMIT lets the commit finish
        enter_edit();
        move(BT_RIGHT);
        move(BT_RIGHT);
        m_up();
        tap(BT_UP);
        set_m = work_m;
        bt[BT_CENTRE] = 1'b1;
        cyc(1);
        bt[BT_CENTRE] = 1'b0;
        want("cl_mode", 64'(2));
        want("cl_pulse", 64'(1));
        want("cl_set", pack_set());
        cyc(1);
        got("cl_mode", 64'(mode));
        got("cl_pulse", 64'(commit));
        got("cl_set", 64'(settings));
        lock = 1'b1;
        want("cl_lock_mode", 64'(3));
        want("cl_lock_pulse", 64'(0));
        want("cl_lock_set", pack_set());
        cyc(1);
        got("cl_lock_mode", 64'(mode));
        got("cl_lock_pulse", 64'(commit));
        got("cl_lock_set", 64'(settings));
        lock = 1'b0;
        want("cl_idle", 64'(0));
        cyc(1);
        got("cl_idle", 64'(mode));

        // asynchronous reset mid-edit
        enter_edit();
        m_up();
        tap(BT_UP);
        move(BT_RIGHT);
        set_m = def_m; work_m = def_m; sel_m = 0;
        want("ar_mode", 64'(0));
        want("ar_set", pack_set());
        want("ar_sel", 64'(0));
        want("ar_dirty", 64'(0));
        want("ar_commit", 64'(0));
        want("ar_val", 64'(def_m[0]));
        #3 rst = 1'b0;
        #1;
        got("ar_mode", 64'(mode));
        got("ar_set", 64'(settings));
        got("ar_sel", 64'(field_sel));
        got("ar_dirty", 64'(dirty));
        got("ar_commit", 64'(commit));
        got("ar_val", 64'(edit_value));
        @(negedge clk);
        rst = 1'b1;
        cyc(1);
        enter_edit();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
